// File: rtl/light_phase_timer_if.sv
// Lamp inputs and phase-expiry outputs between the traffic-light controller and light_phase_timer.
// ped_req exists only when PED_REQUEST_EN is defined.
interface light_phase_timer_if;
    logic       red;
    logic       green;
    logic       yellow;
`ifdef PED_REQUEST_EN
    logic       ped_req;
`endif
    logic       max_r;
    logic       max_g;
    logic       max_y;
    logic       tick;
    logic [3:0] sec_count;
    logic       fault;

    modport master (
        output red, green, yellow,
`ifdef PED_REQUEST_EN
        output ped_req,
`endif
        input  max_r, max_g, max_y, tick, sec_count, fault
    );

    modport slave (
        input  red, green, yellow,
`ifdef PED_REQUEST_EN
        input  ped_req,
`endif
        output max_r, max_g, max_y, tick, sec_count, fault
    );
endinterface

// File: rtl/light_phase_timer.sv
// Prescales clk to a one-second tick, times the lit phase and pulses max_r/max_g/max_y on expiry.
// Optional PED_REQUEST_EN adds a pedestrian request that shortens green to MIN_GREEN_SEC.
module light_phase_timer #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int RED_SEC       = 6,
    parameter int GREEN_SEC     = 4,
    parameter int YELLOW_SEC    = 2,
    parameter int MIN_GREEN_SEC = 2
) (
    input logic                clk,
    input logic                reset,
    light_phase_timer_if.slave bus
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [2:0]     PH_RED    = 3'b100;
    localparam logic [2:0]     PH_GREEN  = 3'b010;
    localparam logic [2:0]     PH_YELLOW = 3'b001;

    function automatic logic [3:0] phase_limit(input logic [2:0] ph);
        case (ph)
            PH_RED:    return 4'(RED_SEC);
            PH_GREEN:  return 4'(GREEN_SEC);
            PH_YELLOW: return 4'(YELLOW_SEC);
            default:   return 4'd0;
        endcase
    endfunction

    logic [2:0]    phase;
    logic [2:0]    prev_phase;
    logic [PW-1:0] prescaler;
    logic [3:0]    sec_count;
    logic [3:0]    sec_next;
    logic [3:0]    limit;
    logic          valid;
    logic          entry;
    logic          tick;
    logic          expire;
    logic          ped_early;
    logic          max_r;
    logic          max_g;
    logic          max_y;
    logic          fault;

    assign phase    = {bus.red, bus.green, bus.yellow};
    assign valid    = (phase == PH_RED) || (phase == PH_GREEN) || (phase == PH_YELLOW);
    assign entry    = valid && (phase != prev_phase);
    assign tick     = valid && !entry && (prescaler == PRE_LAST);
    assign limit    = phase_limit(phase);
    assign sec_next = sec_count + 4'd1;
    assign expire   = tick && ((sec_next == limit) || ped_early);

`ifdef PED_REQUEST_EN
    logic ped_pending;

    assign ped_early = ped_pending && (phase == PH_GREEN) && (sec_next >= 4'(MIN_GREEN_SEC));

    // A new request in the same cycle as the green pulse keeps the request pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending <= 1'b0;
        end else if (bus.ped_req) begin
            ped_pending <= 1'b1;
        end else if (max_g) begin
            ped_pending <= 1'b0;
        end
    end
`else
    assign ped_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_phase <= 3'b000;
            prescaler  <= '0;
            sec_count  <= 4'd0;
            fault      <= 1'b0;
            max_r      <= 1'b0;
            max_g      <= 1'b0;
            max_y      <= 1'b0;
        end else begin
            prev_phase <= phase;
            fault      <= !valid;
            max_r      <= expire && (phase == PH_RED);
            max_g      <= expire && (phase == PH_GREEN);
            max_y      <= expire && (phase == PH_YELLOW);
            // Invalid lamps and phase entries both restart timing from zero.
            if (!valid || entry) begin
                prescaler <= '0;
                sec_count <= 4'd0;
            end else begin
                prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
                if (tick) begin
                    sec_count <= expire ? 4'd0 : sec_next;
                end
            end
        end
    end

    assign bus.max_r     = max_r;
    assign bus.max_g     = max_g;
    assign bus.max_y     = max_y;
    assign bus.tick      = tick;
    assign bus.sec_count = sec_count;
    assign bus.fault     = fault;

endmodule
